// File: rtl/rom_stream_reader.sv
// Streams a programmed run of words from a registered ROM onto a valid/ready port,
// tracking the ROM's one-cycle latency. Optional checksum output: ROM_READER_CHECKSUM_EN.
module rom_stream_reader #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);

    localparam int DEPTH = 4;
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [AW:0]   remain_reg, remain_next;
    logic          done_reg, done_next;
    logic [1:0]    inflight_reg;
    logic [1:0]    inflight_last_reg;
    logic [DW-1:0] fifo_data_reg [DEPTH];
    logic          fifo_last_reg [DEPTH];
    logic [1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [2:0]    fifo_count_reg;

    logic          issue, issue_last, csum_clr;
    logic          push, pop, credit_ok;
    logic [AW:0]   len_sat;
    logic [3:0]    occupancy;

    assign len_sat  = (len > MAX_LEN) ? MAX_LEN : len;
    assign m_valid  = (fifo_count_reg != 3'd0);
    assign m_data   = fifo_data_reg[rd_ptr_reg];
    assign m_last   = m_valid && fifo_last_reg[rd_ptr_reg];
    assign pop      = m_valid && m_ready;
    // Slot 1 of the tag pipe lines up with the ROM word for that address.
    assign push     = inflight_reg[1];
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign rom_addr = addr_reg;

    // Entries held after this cycle's pop plus everything still in flight.
    assign occupancy = {1'b0, fifo_count_reg} - {3'b000, pop}
                     + {3'b000, inflight_reg[0]} + {3'b000, inflight_reg[1]};
    assign credit_ok = (occupancy <= 4'(DEPTH - 1));

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        done_next   = 1'b0;
        issue       = 1'b0;
        issue_last  = 1'b0;
        csum_clr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    csum_clr = 1'b1;
                    if (len_sat == '0) begin
                        done_next = 1'b1;
                    end else begin
                        // The FIFO and tag pipe are empty here, so the first read is always allowed.
                        issue       = 1'b1;
                        issue_last  = (len_sat == (AW+1)'(1));
                        addr_next   = base;
                        remain_next = len_sat - (AW+1)'(1);
                        state_next  = issue_last ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    issue_last  = (remain_reg == (AW+1)'(1));
                    addr_next   = addr_reg + AW'(1);
                    remain_next = remain_reg - (AW+1)'(1);
                    if (issue_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            remain_reg        <= '0;
            done_reg          <= 1'b0;
            inflight_reg      <= '0;
            inflight_last_reg <= '0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            fifo_count_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            remain_reg        <= remain_next;
            done_reg          <= done_next;
            inflight_reg      <= {inflight_reg[0], issue};
            inflight_last_reg <= {inflight_last_reg[0], issue_last};
            wr_ptr_reg        <= wr_ptr_reg + {1'b0, push};
            rd_ptr_reg        <= rd_ptr_reg + {1'b0, pop};
            fifo_count_reg    <= fifo_count_reg + {2'b00, push} - {2'b00, pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_last_reg[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == 2'(gi))) begin
                    fifo_data_reg[gi] <= rom_data;
                    fifo_last_reg[gi] <= inflight_last_reg[1];
                end
            end
        end
    endgenerate

`ifdef ROM_READER_CHECKSUM_EN
    logic [DW-1:0] csum_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_reg <= '0;
        end else if (csum_clr) begin
            csum_reg <= '0;
        end else if (pop) begin
            csum_reg <= csum_reg ^ m_data;
        end
    end

    assign csum = csum_reg;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: behavioural ROM (addr i -> 0x1000_0000+i),
// expected words queued at start, compared on each output handshake.
module tb_rom_stream_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [AW:0]   len   = '0;
    logic          busy, done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef ROM_READER_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    rom_stream_reader #(.AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
`ifdef ROM_READER_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always #5 clock = ~clock;

    // Registered behavioural ROM, free-running with no enable.
    always @(posedge clock) rom_data <= 32'h1000_0000 + {{(DW-AW){1'b0}}, rom_addr};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW:0]   exp_q [$];
    int            hs_count     = 0;
    logic          stall_prev   = 1'b0;
    logic [DW-1:0] held_data    = '0;
    logic          held_last    = 1'b0;
    logic          hs_last_prev = 1'b0;
    logic          len0_arm     = 1'b0;
    logic          len0_stage   = 1'b0;
    logic          toggle_en    = 1'b0;
    logic          fifo_watch   = 1'b0;
    logic [DW-1:0] csum_model   = '0;

    // Ready driver: held high, or the repeating 1,0,0,1 pattern.
    initial begin
        int k = 0;
        forever begin
            @(posedge clock);
            #1;
            if (toggle_en) begin
                m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                k++;
            end else begin
                m_ready = 1'b1;
                k = 0;
            end
        end
    end

    // Monitor: samples at the falling edge, ahead of the handshake edge.
    always @(negedge clock) begin
        logic [DW:0] e;
        if (!reset) begin
            stall_prev   = 1'b0;
            hs_last_prev = 1'b0;
            len0_stage   = 1'b0;
            len0_arm     = 1'b0;
        end else begin
            check("done", done, hs_last_prev | len0_stage);
`ifdef ROM_READER_CHECKSUM_EN
            if (hs_last_prev) check("csum", csum, csum_model);
`endif
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, held_data);
                check("hold_last", m_last, held_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e[DW-1:0]);
                    check("last", m_last, e[DW]);
                end
                $display("word %0d data=%h last=%0b", hs_count, m_data, m_last);
                hs_count++;
                csum_model ^= m_data;
            end
            if (fifo_watch) check("fifo_le4", dut.fifo_count_reg <= 3'd4, 1);
            hs_last_prev = m_valid && m_ready && m_last;
            len0_stage   = len0_arm;
            len0_arm     = 1'b0;
            stall_prev   = m_valid && !m_ready;
            held_data    = m_data;
            held_last    = m_last;
        end
    end

    task automatic launch(input int b, input int l);
        int n;
        @(posedge clock);
        #1;
        start = 1'b1;
        base  = AW'(b);
        len   = (AW+1)'(l);
        n = (l > 32) ? 32 : l;
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), 32'h1000_0000 + DW'((b + i) % 32)});
        csum_model = '0;
        if (l == 0) len0_arm = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drained();
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drained", exp_q.size(), 0);
        check("busy_end", busy, 0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int h0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        reset = 1'b1;

        // Basic run: latency, throughput and completion timing.
        launch(0, 4);
        check("e0_busy", busy, 1);
        check("e0_addr", rom_addr, 0);
        check("e0_valid", m_valid, 0);
        @(posedge clock); #1;
        check("e1_valid", m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("stream_valid", m_valid, 1);
            check("stream_last", m_last, (i == 3));
        end
        @(posedge clock); #1;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", m_valid, 0);
        wait_drained();

        // Address wrap.
        launch(30, 4);
        wait_drained();

        // Zero length: done pulse, nothing else.
        launch(0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("len0_busy", busy, 0);
            check("len0_valid", m_valid, 0);
        end

        // Oversized length saturates to the full depth.
        h0 = hs_count;
        launch(5, 63);
        wait_drained();
        check("len63_words", hs_count - h0, 32);

        // Back-pressure with ready toggling 1,0,0,1.
        toggle_en  = 1'b1;
        fifo_watch = 1'b1;
        h0 = hs_count;
        launch(0, 32);
        wait_drained();
        check("bp_words", hs_count - h0, 32);
        toggle_en  = 1'b0;
        fifo_watch = 1'b0;

        // Reset mid-run, then a fresh short run.
        h0 = hs_count;
        launch(0, 16);
        for (int c = 0; c < 100; c++) begin
            if (hs_count - h0 >= 5) break;
            @(posedge clock); #1;
        end
        check("mid_progress", (hs_count - h0) >= 5, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_addr", rom_addr, 0);
        check("mid_valid", m_valid, 0);
        check("mid_data", m_data, 0);
        check("mid_last", m_last, 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        h0 = hs_count;
        launch(8, 2);
        wait_drained();
        check("post_rst_words", hs_count - h0, 2);

`ifdef ROM_READER_CHECKSUM_EN
        launch(0, 2);
        wait_drained();
        check("csum_final", csum, 32'h0000_0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
